// File: rtl/wb_port_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Optional build macro WB_ARB_BYPASS_EN is consumed by wb_port_arb.sv.
package wb_port_arb_pkg;

   localparam int unsigned REG_BUS_W  = 64;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [REG_BUS_W-1:0] ZERO_WORD     = '0;
   localparam logic                 REG_W_DISABLE = 1'b0;
   localparam logic                 REG_W_ENABLE  = 1'b1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Write-port source, kept as a named encoding for trace/debug
   typedef enum logic [1:0] {
      WB_GRANT_NONE = 2'd0,
      WB_GRANT_PIPE = 2'd1,
      WB_GRANT_LU   = 2'd2,
      WB_GRANT_BYP  = 2'd3
   } wb_grant_e;

   // Register x0 is hard-wired; writes to it are never real writes
   function automatic logic addr_live(input reg_addr_t a);
      return a != '0;
   endfunction

endpackage

// File: rtl/wb_port_arb_fifo.sv
// Small synchronous FIFO for long-unit results with an associative
// destination-address match over the occupied entries.
module wb_arb_fifo
   import wb_port_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  reg_addr_t                  push_addr,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output reg_addr_t                  head_addr,
   output logic [DATA_W-1:0]          head_data,
   output logic [$clog2(DEPTH):0]     count,
   input  reg_addr_t                  query_addr,
   output logic                       hit
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   reg_addr_t         addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_push   = push && (count != CNT_W'(DEPTH));
   assign do_pop    = pop && (count != '0);
   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Entry storage; contents are qualified by count so need no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   // Pending-write hazard match over occupied entries, x0 never matches
   always_comb begin
      hit = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if ((CNT_W'(k) < count) && addr_live(query_addr) &&
             (addr_mem[rd_ptr + PTR_W'(k)] == query_addr))
            hit = 1'b1;
      end
   end

endmodule

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: in-order pipeline write-back has
// priority over a FIFO-buffered long-latency unit, with a starvation
// counter forcing a long-unit grant. Optional macro WB_ARB_BYPASS_EN
// lets a long-unit result skip an empty FIFO when the port is idle.
module wb_port_arb
   import wb_port_arb_pkg::*;
#(
   parameter int unsigned DATA_W     = REG_BUS_W,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pipe_w_ena_i,
   input  logic [4:0]                    pipe_w_addr_i,
   input  logic [DATA_W-1:0]             pipe_w_data_i,
   output logic                          pipe_stall_o,
   input  logic                          lu_valid_i,
   output logic                          lu_ready_o,
   input  logic [4:0]                    lu_addr_i,
   input  logic [DATA_W-1:0]             lu_data_i,
   input  logic [4:0]                    query_addr_i,
   output logic                          pend_hit_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          rd_w_ena_o,
   output logic [4:0]                    rd_w_addr_o,
   output logic [DATA_W-1:0]             rd_w_data_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

   logic              push;
   logic              pop;
   reg_addr_t         head_addr;
   logic [DATA_W-1:0] head_data;
   logic [CNT_W-1:0]  count;
   logic              fifo_empty;
   logic              pipe_req;
   logic              force_lu;
   logic [STV_W-1:0]  starve_cnt;
   wb_grant_e         grant;

   wb_arb_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (lu_addr_i),
      .push_data  (lu_data_i),
      .pop        (pop),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (count),
      .query_addr (query_addr_i),
      .hit        (pend_hit_o)
   );

   assign fifo_count_o = count;
   assign fifo_empty   = (count == '0);
   assign lu_ready_o   = (count != CNT_W'(FIFO_DEPTH));
   assign pipe_req     = pipe_w_ena_i && addr_live(pipe_w_addr_i);
   assign force_lu     = !fifo_empty && (starve_cnt == STV_W'(STARVE_MAX));

   // Grant selection: forced drain, then pipeline, then FIFO head
   always_comb begin
      grant        = WB_GRANT_NONE;
      pop          = 1'b0;
      pipe_stall_o = 1'b0;
      push         = lu_valid_i && lu_ready_o;
      if (force_lu) begin
         grant        = WB_GRANT_LU;
         pop          = 1'b1;
         pipe_stall_o = pipe_req;
      end else if (pipe_req) begin
         grant = WB_GRANT_PIPE;
      end else if (!fifo_empty) begin
         grant = WB_GRANT_LU;
         pop   = 1'b1;
`ifdef WB_ARB_BYPASS_EN
      end else if (lu_valid_i) begin
         grant = WB_GRANT_BYP;
         push  = 1'b0;
`endif
      end
   end

   // Registered write port; a popped x0 entry is consumed without a write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_w_ena_o  <= REG_W_DISABLE;
         rd_w_addr_o <= '0;
         rd_w_data_o <= '0;
      end else begin
         case (grant)
            WB_GRANT_PIPE: begin
               rd_w_ena_o  <= REG_W_ENABLE;
               rd_w_addr_o <= pipe_w_addr_i;
               rd_w_data_o <= pipe_w_data_i;
            end
            WB_GRANT_LU: begin
               rd_w_ena_o  <= addr_live(head_addr);
               rd_w_addr_o <= head_addr;
               rd_w_data_o <= head_data;
            end
            WB_GRANT_BYP: begin
               rd_w_ena_o  <= addr_live(lu_addr_i);
               rd_w_addr_o <= lu_addr_i;
               rd_w_data_o <= lu_data_i;
            end
            default: rd_w_ena_o <= REG_W_DISABLE;
         endcase
      end
   end

   // Consecutive cycles a buffered result was denied the port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (fifo_empty || pop) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + STV_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed self-checking bench for wb_port_arb (default parameters).
module tb_wb_port_arb;

   logic        clk;
   logic        rst;
   logic        pipe_w_ena_i;
   logic [4:0]  pipe_w_addr_i;
   logic [63:0] pipe_w_data_i;
   logic        pipe_stall_o;
   logic        lu_valid_i;
   logic        lu_ready_o;
   logic [4:0]  lu_addr_i;
   logic [63:0] lu_data_i;
   logic [4:0]  query_addr_i;
   logic        pend_hit_o;
   logic [1:0]  fifo_count_o;
   logic        rd_w_ena_o;
   logic [4:0]  rd_w_addr_o;
   logic [63:0] rd_w_data_o;

   int checks   = 0;
   int failures = 0;

   wb_port_arb #(.DATA_W(64), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_w_ena_i  (pipe_w_ena_i),
      .pipe_w_addr_i (pipe_w_addr_i),
      .pipe_w_data_i (pipe_w_data_i),
      .pipe_stall_o  (pipe_stall_o),
      .lu_valid_i    (lu_valid_i),
      .lu_ready_o    (lu_ready_o),
      .lu_addr_i     (lu_addr_i),
      .lu_data_i     (lu_data_i),
      .query_addr_i  (query_addr_i),
      .pend_hit_o    (pend_hit_o),
      .fifo_count_o  (fifo_count_o),
      .rd_w_ena_o    (rd_w_ena_o),
      .rd_w_addr_o   (rd_w_addr_o),
      .rd_w_data_o   (rd_w_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge so registered outputs are settled
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic ena, input logic [4:0] addr,
                         input logic [63:0] data);
      chk({tag, "_ena"}, 64'(rd_w_ena_o), 64'(ena));
      chk({tag, "_addr"}, 64'(rd_w_addr_o), 64'(addr));
      chk({tag, "_data"}, rd_w_data_o, data);
   endtask

   task automatic set_pipe(input logic ena, input logic [4:0] addr, input logic [63:0] data);
      pipe_w_ena_i  = ena;
      pipe_w_addr_i = addr;
      pipe_w_data_i = data;
   endtask

   task automatic set_lu(input logic vld, input logic [4:0] addr, input logic [63:0] data);
      lu_valid_i = vld;
      lu_addr_i  = addr;
      lu_data_i  = data;
   endtask

   initial begin
      rst = 1'b0;
      set_pipe(1'b0, 5'd0, 64'd0);
      set_lu(1'b0, 5'd0, 64'd0);
      query_addr_i = 5'd0;
      tick();
      tick();
      // reset state
      chk_wr("rst", 1'b0, 5'd0, 64'd0);
      chk("rst_count", 64'(fifo_count_o), 64'd0);
      chk("rst_ready", 64'(lu_ready_o), 64'd1);
      chk("rst_stall", 64'(pipe_stall_o), 64'd0);
      rst = 1'b1;
      tick();
      chk("idle_ena", 64'(rd_w_ena_o), 64'd0);

      // pipeline write, latency 1
      set_pipe(1'b1, 5'd3, 64'hA);
      #1 chk("pipe_stall0", 64'(pipe_stall_o), 64'd0);
      tick();
      chk_wr("pipe_wr", 1'b1, 5'd3, 64'hA);

      // priority and starvation: x7 waits 4 cycles then is forced in
      set_lu(1'b1, 5'd7, 64'h55);
      #1 chk("prio_ready", 64'(lu_ready_o), 64'd1);
      tick();
      set_lu(1'b0, 5'd0, 64'd0);
      chk("prio_count", 64'(fifo_count_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("prio_nostall", 64'(pipe_stall_o), 64'd0);
         tick();
         chk_wr("prio_pipe", 1'b1, 5'd3, 64'hA);
      end
      chk("prio_stall", 64'(pipe_stall_o), 64'd1);
      tick();
      chk_wr("prio_forced", 1'b1, 5'd7, 64'h55);
      chk("prio_count0", 64'(fifo_count_o), 64'd0);
      chk("prio_unstall", 64'(pipe_stall_o), 64'd0);
      tick();
      chk_wr("prio_held", 1'b1, 5'd3, 64'hA);

      // full boundary with pipe busy: three back-to-back pushes
      set_lu(1'b1, 5'd8, 64'h1);
      #1 chk("full_rdy_a", 64'(lu_ready_o), 64'd1);
      tick();
      chk("full_cnt1", 64'(fifo_count_o), 64'd1);
      set_lu(1'b1, 5'd9, 64'h2);
      #1 chk("full_rdy_b", 64'(lu_ready_o), 64'd1);
      tick();
      chk("full_cnt2", 64'(fifo_count_o), 64'd2);
      set_lu(1'b1, 5'd10, 64'h3);
      #1 chk("full_rdy_c", 64'(lu_ready_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_cnt_hold", 64'(fifo_count_o), 64'd2);
         chk("full_notready", 64'(lu_ready_o), 64'd0);
      end
      chk("full_stall", 64'(pipe_stall_o), 64'd1);
      chk("full_ready_pop", 64'(lu_ready_o), 64'd0);
      tick();
      chk_wr("full_pop8", 1'b1, 5'd8, 64'h1);
      chk("full_cnt_after_pop", 64'(fifo_count_o), 64'd1);
      chk("full_ready_free", 64'(lu_ready_o), 64'd1);
      tick();
      chk_wr("full_pipe", 1'b1, 5'd3, 64'hA);
      chk("full_cnt_third", 64'(fifo_count_o), 64'd2);
      set_lu(1'b0, 5'd0, 64'd0);
      set_pipe(1'b0, 5'd0, 64'd0);
      tick();
      chk_wr("drain9", 1'b1, 5'd9, 64'h2);
      tick();
      chk_wr("drain10", 1'b1, 5'd10, 64'h3);
      chk("drain_cnt", 64'(fifo_count_o), 64'd0);
      tick();
      chk("drain_idle", 64'(rd_w_ena_o), 64'd0);

      // x0 handling
      set_pipe(1'b1, 5'd2, 64'h5);
      set_lu(1'b1, 5'd9, 64'h77);
      tick();
      chk_wr("x0_pipe", 1'b1, 5'd2, 64'h5);
      chk("x0_cnt1", 64'(fifo_count_o), 64'd1);
      set_lu(1'b0, 5'd0, 64'd0);
      set_pipe(1'b1, 5'd0, 64'hFF);
      #1 chk("x0_nostall", 64'(pipe_stall_o), 64'd0);
      tick();
      chk_wr("x0_fifo9", 1'b1, 5'd9, 64'h77);
      chk("x0_cnt0", 64'(fifo_count_o), 64'd0);
      set_pipe(1'b1, 5'd2, 64'h5);
      set_lu(1'b1, 5'd0, 64'h33);
      tick();
      chk_wr("x0_pipe2", 1'b1, 5'd2, 64'h5);
      chk("x0_cnt_e0", 64'(fifo_count_o), 64'd1);
      set_lu(1'b0, 5'd0, 64'd0);
      set_pipe(1'b0, 5'd0, 64'd0);
      query_addr_i = 5'd0;
      #1 chk("x0_query0", 64'(pend_hit_o), 64'd0);
      tick();
      chk("x0_pop_ena", 64'(rd_w_ena_o), 64'd0);
      chk("x0_pop_cnt", 64'(fifo_count_o), 64'd0);

      // hazard query
      set_pipe(1'b1, 5'd2, 64'h6);
      set_lu(1'b1, 5'd12, 64'hC);
      tick();
      set_lu(1'b0, 5'd0, 64'd0);
      query_addr_i = 5'd12;
      #1 chk("hz_hit12", 64'(pend_hit_o), 64'd1);
      query_addr_i = 5'd0;
      #1 chk("hz_hit0", 64'(pend_hit_o), 64'd0);
      query_addr_i = 5'd13;
      #1 chk("hz_hit13", 64'(pend_hit_o), 64'd0);
      set_pipe(1'b0, 5'd0, 64'd0);
      query_addr_i = 5'd12;
      tick();
      chk_wr("hz_pop12", 1'b1, 5'd12, 64'hC);
      chk("hz_after_pop", 64'(pend_hit_o), 64'd0);

      // long-unit latency from an idle port
      set_lu(1'b1, 5'd4, 64'h99);
      #1 chk("lat_ready", 64'(lu_ready_o), 64'd1);
      tick();
      set_lu(1'b0, 5'd0, 64'd0);
`ifdef WB_ARB_BYPASS_EN
      chk_wr("lat_byp", 1'b1, 5'd4, 64'h99);
      chk("lat_byp_cnt", 64'(fifo_count_o), 64'd0);
      tick();
      chk("lat_byp_idle", 64'(rd_w_ena_o), 64'd0);
`else
      chk("lat_n1_ena", 64'(rd_w_ena_o), 64'd0);
      chk("lat_n1_cnt", 64'(fifo_count_o), 64'd1);
      tick();
      chk_wr("lat_n2", 1'b1, 5'd4, 64'h99);
      chk("lat_n2_cnt", 64'(fifo_count_o), 64'd0);
`endif

      // reset mid-operation
      set_pipe(1'b1, 5'd5, 64'h11);
      set_lu(1'b1, 5'd20, 64'h1);
      tick();
      set_lu(1'b1, 5'd21, 64'h2);
      tick();
      chk("mrst_cnt2", 64'(fifo_count_o), 64'd2);
      chk_wr("mrst_pre", 1'b1, 5'd5, 64'h11);
      set_lu(1'b0, 5'd0, 64'd0);
      #1 rst = 1'b0;
      #1;
      chk_wr("mrst_async", 1'b0, 5'd0, 64'd0);
      chk("mrst_cnt0", 64'(fifo_count_o), 64'd0);
      tick();
      chk("mrst_hold_ena", 64'(rd_w_ena_o), 64'd0);
      set_pipe(1'b0, 5'd0, 64'd0);
      rst = 1'b1;
      tick();
      chk("mrst_rel_ena", 64'(rd_w_ena_o), 64'd0);
      chk("mrst_rel_cnt", 64'(fifo_count_o), 64'd0);
      tick();
      chk("mrst_nostale", 64'(rd_w_ena_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_port_arb.md
Name: wb_port_arb

Overview:
- Arbiter for the single register-file write port.
- Shares the port between two requesters:
  - the in-order pipeline write-back (wb stage output);
  - a long-latency unit (mul/div, misaligned load), buffered in a small FIFO.
- The pipeline has priority. A starvation counter forces a long-unit grant and stalls the pipeline for one cycle.
- Sits between wb stage / long unit and the regfile write port; all port outputs are registered.

Parameters:
- DATA_W, 64, write data width (matches REG_BUS).
- FIFO_DEPTH, 2, long-unit buffer entries; power of 2, minimum 2.
- STARVE_MAX, 4, consecutive denied cycles before a forced long-unit grant; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- pipe_w_ena_i  in  1  pipeline write request.
- pipe_w_addr_i  in  5  pipeline destination register.
- pipe_w_data_i  in  DATA_W  pipeline write data.
- pipe_stall_o  out  1  combinational; pipeline write denied this cycle, hold inputs.
- lu_valid_i  in  1  long-unit result valid.
- lu_ready_o  out  1  long-unit push accepted (FIFO not full).
- lu_addr_i  in  5  long-unit destination register.
- lu_data_i  in  DATA_W  long-unit result.
- query_addr_i  in  5  hazard query address.
- pend_hit_o  out  1  combinational; query_addr_i matches a valid FIFO entry (x0 never hits).
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- rd_w_ena_o  out  1  registered regfile write enable.
- rd_w_addr_o  out  5  registered regfile write address.
- rd_w_data_o  out  DATA_W  registered regfile write data.

Behaviour:
- Reset (rst low, asynchronous):
  - rd_w_ena_o=0, rd_w_addr_o=0, rd_w_data_o=0;
  - FIFO pointers and count = 0;
  - starvation counter = 0;
  - an in-flight write is discarded.
- Push:
  - lu_valid_i && lu_ready_o writes {addr,data} at the tail.
  - lu_ready_o = (count != FIFO_DEPTH), derived from the registered count.
  - A push into an empty FIFO cannot be popped in the same cycle (no bypass unless the Optional Feature is enabled).
- Grant (evaluated each cycle, result registered to outputs at the next edge):
  - force = !empty && (starve_cnt == STARVE_MAX).
  - force: pop head, write it; pipe_stall_o=1 if pipe_w_ena_i.
  - else pipe_w_ena_i && pipe_w_addr_i != 0: write pipe; FIFO not popped.
  - else !empty: pop head, write it.
  - else: rd_w_ena_o=0 next cycle.
- Address x0:
  - A pipe write to x0 is dropped: no grant consumed, no stall.
  - A popped FIFO entry with addr 0 is consumed with rd_w_ena_o=0.
- Starvation counter:
  - increments when !empty and no pop this cycle, saturating at STARVE_MAX;
  - clears on any pop or when empty.
- Latency:
  - pipeline request to rd_w_*: 1 cycle;
  - long unit, push in cycle N: earliest output in cycle N+2.
- Full FIFO with simultaneous pop: lu_ready_o is still 0 that cycle; the freed slot is visible next cycle.
- Pointers wrap modulo FIFO_DEPTH. The count is distinct from the pointers, so full and empty are unambiguous.
- Ordering between the two sources is not enforced here. The upstream scoreboard uses pend_hit_o to block the issue of a dependent instruction.

Optional Feature:
- Macro WB_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, no pipe write (non-x0) is requested, and lu_valid_i is high:
  - the long-unit request is granted directly (not pushed);
  - output appears next cycle, latency 1;
  - lu_ready_o stays 1.
- Undefined: all long-unit results pass through the FIFO, latency ≥2.

Decomposition:
- Shared defines package (defines.v):
  - REG_BUS, ZERO_WORD, REG_W_DISABLE/ENABLE;
  - a new REG_ADDR_BUS [4:0];
  - WB_GRANT_* source encodings (NONE, PIPE, LU) for debug/trace.
- One natural sub-module: wb_arb_fifo. It is a parameterised synchronous FIFO providing push/pop/count/head and the associative address match used for pend_hit_o.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, pipe writing x5=0x11, rst low for 1 cycle -> rd_w_ena_o=0 immediately; after release, count=0 and no stale write appears.
- Priority: pipe writes x3=0xA continuously while the long unit pushes x7=0x55 -> x3 is written each cycle; after STARVE_MAX=4 denied cycles, pipe_stall_o=1 for exactly one cycle and x7=0x55 is written; the held pipe write x3 lands the next cycle.
- Full boundary: 3 back-to-back pushes with the pipe busy -> lu_ready_o drops after 2, the third is accepted only after the first pop, and fifo_count_o sequence is 1,2,2,…
- x0 handling: pipe write x0 plus FIFO entry x9=0x77 -> x9 is written next cycle with no stall; FIFO entry x0 -> popped with rd_w_ena_o=0.
- Hazard query: FIFO holds x12 -> query 12 gives pend_hit_o=1; after its pop, pend_hit_o=0; query 0 always gives 0.
- Bypass (WB_ARB_BYPASS_EN): idle pipe, empty FIFO, push x4=0x99 in cycle N -> rd_w_ena_o=1, x4=0x99 in cycle N+1, fifo_count_o stays 0; with the macro undefined, the write appears in N+2.
